// File: rtl/eth_lane_pkg.sv
// Shared lane geometry, sequencer state encoding and a lane-mask helper
// for the byte lane sequencer slice.
package eth_lane_pkg;

    localparam int unsigned LANES = 8;
    localparam int unsigned SEL_W = 3;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    function automatic logic [LANES-1:0] lane_bit(input logic [SEL_W-1:0] sel);
        return LANES'(1) << sel;
    endfunction

endpackage

// File: rtl/byte_lane_sequencer_if.sv
// Word-in / byte-out bus of the byte lane sequencer; slave is the sequencer
// side, master the upstream/downstream environment side.
interface byte_lane_sequencer_if;
    import eth_lane_pkg::*;

    logic                   in_valid;
    logic                   in_ready;
    logic [LANES*8-1:0]     in_data;
    logic [LANES-1:0]       in_keep;
    logic                   in_last;
    logic [LANES*8-1:0]     word_q;
    logic [SEL_W-1:0]       mux_sel;
    logic                   mux_en;
    logic                   byte_valid;
    logic                   byte_last;
    logic                   out_ready;

    modport slave (
        input  in_valid, in_data, in_keep, in_last, out_ready,
        output in_ready, word_q, mux_sel, mux_en, byte_valid, byte_last
    );

    modport master (
        output in_valid, in_data, in_keep, in_last, out_ready,
        input  in_ready, word_q, mux_sel, mux_en, byte_valid, byte_last
    );

endinterface

// File: rtl/lane_prio_enc.sv
// Lowest-set-bit priority encoder over the lane mask, with an any-bit flag.
module lane_prio_enc
    import eth_lane_pkg::*;
(
    input  logic [LANES-1:0] mask,
    output logic [SEL_W-1:0] idx,
    output logic             any
);

    always_comb begin
        idx = '0;
        any = |mask;
        // Scan downwards so the lowest set lane is the last one written.
        for (int unsigned i = LANES; i > 0; i--) begin
            if (mask[i-1]) idx = SEL_W'(i - 1);
        end
    end

endmodule

// File: rtl/byte_lane_sequencer.sv
// Serialises the kept lanes of 64-bit words into a byte stream by steering a
// downstream 8:1 mux bank, one byte per cycle with no inter-word bubble.
module byte_lane_sequencer
    import eth_lane_pkg::*;
#(
    parameter logic IDLE_EN = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset,
    byte_lane_sequencer_if.slave bus
);

    state_t             state;
    logic [LANES*8-1:0] word_q;
    logic [LANES-1:0]   rem_mask;
    logic               last_q;
    logic [SEL_W-1:0]   mux_sel;
    logic               mux_en;
    logic               byte_valid;
    logic               byte_last;

    logic [LANES-1:0]   rem_next;
    logic [LANES-1:0]   acc_rest;
    logic [LANES-1:0]   adv_rest;
    logic [SEL_W-1:0]   acc_sel;
    logic [SEL_W-1:0]   adv_sel;
    logic               acc_any;
    logic               adv_any;
    logic               rem_single;
    logic               in_ready;
    logic               load;
    logic               advance;

    lane_prio_enc u_acc_enc (
        .mask (bus.in_keep),
        .idx  (acc_sel),
        .any  (acc_any)
    );

    lane_prio_enc u_adv_enc (
        .mask (rem_next),
        .idx  (adv_sel),
        .any  (adv_any)
    );

    always_comb begin
        rem_next   = rem_mask & ~lane_bit(mux_sel);
        rem_single = (rem_mask != '0) && ((rem_mask & (rem_mask - 8'd1)) == '0);
        // Gated by reset so in_ready reads 0 while reset is held.
        in_ready   = reset && ((state == IDLE) || (rem_single && bus.out_ready));
        advance    = (state == SEND) && bus.out_ready;
        load       = bus.in_valid && in_ready && acc_any;
        acc_rest   = bus.in_keep & ~lane_bit(acc_sel);
        adv_rest   = rem_next & ~lane_bit(adv_sel);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            word_q     <= '0;
            rem_mask   <= '0;
            last_q     <= 1'b0;
            mux_sel    <= '0;
            mux_en     <= 1'b0;
            byte_valid <= 1'b0;
            byte_last  <= 1'b0;
        end else if (load) begin
            state      <= SEND;
            word_q     <= bus.in_data;
            rem_mask   <= bus.in_keep;
            last_q     <= bus.in_last;
            mux_sel    <= acc_sel;
            mux_en     <= 1'b1;
            byte_valid <= 1'b1;
            byte_last  <= bus.in_last && (acc_rest == '0);
        end else begin
            case (state)
                IDLE: begin
                    mux_en     <= IDLE_EN;
                    byte_valid <= 1'b0;
                    byte_last  <= 1'b0;
                end
                SEND: begin
                    if (advance) begin
                        rem_mask <= rem_next;
                        if (adv_any) begin
                            mux_sel   <= adv_sel;
                            byte_last <= last_q && (adv_rest == '0);
                        end else begin
                            state      <= IDLE;
                            mux_en     <= IDLE_EN;
                            byte_valid <= 1'b0;
                            byte_last  <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.word_q     = word_q;
    assign bus.mux_sel    = mux_sel;
    assign bus.mux_en     = mux_en;
    assign bus.byte_valid = byte_valid;
    assign bus.byte_last  = byte_last;

endmodule

// File: tb/tb_byte_lane_sequencer.sv
// Directed, table-driven bench for byte_lane_sequencer with hand-written
// sequences for stall, back-to-back, empty-keep and mid-word reset.
module tb_byte_lane_sequencer;

    logic clk;
    logic reset;
    int unsigned total;
    int unsigned bad;

    byte_lane_sequencer_if bus ();

    byte_lane_sequencer #(.IDLE_EN(1'b0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // sels: nibble j holds the lane expected on the j-th presented byte.
    typedef struct {
        logic [7:0]  keep;
        logic        last;
        logic [63:0] data;
        int unsigned n;
        logic [31:0] sels;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int unsigned k);
        vec_t v;
        v = vecs[k];
        chk($sformatf("v%0d idle_ready", k), 64'(bus.in_ready), 64'd1);
        bus.in_valid  = 1'b1;
        bus.in_data   = v.data;
        bus.in_keep   = v.keep;
        bus.in_last   = v.last;
        bus.out_ready = 1'b1;
        @(negedge clk);
        // Garbage on the inputs while not accepted must not disturb the word.
        bus.in_valid = 1'b0;
        bus.in_data  = ~v.data;
        bus.in_keep  = 8'hFF;
        bus.in_last  = ~v.last;
        for (int unsigned j = 0; j < v.n; j++) begin
            chk($sformatf("v%0d b%0d valid", k, j), 64'(bus.byte_valid), 64'd1);
            chk($sformatf("v%0d b%0d sel", k, j), 64'(bus.mux_sel), 64'(v.sels[4*j +: 3]));
            chk($sformatf("v%0d b%0d last", k, j), 64'(bus.byte_last), 64'(v.last && (j == v.n - 1)));
            chk($sformatf("v%0d b%0d en", k, j), 64'(bus.mux_en), 64'd1);
            chk($sformatf("v%0d b%0d word", k, j), bus.word_q, v.data);
            chk($sformatf("v%0d b%0d ready", k, j), 64'(bus.in_ready), 64'(j == v.n - 1));
            @(negedge clk);
        end
        chk($sformatf("v%0d end valid", k), 64'(bus.byte_valid), 64'd0);
        chk($sformatf("v%0d end last", k), 64'(bus.byte_last), 64'd0);
        chk($sformatf("v%0d end en", k), 64'(bus.mux_en), 64'd0);
        chk($sformatf("v%0d end ready", k), 64'(bus.in_ready), 64'd1);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        vecs[0] = '{keep: 8'hFF, last: 1'b1, data: 64'h0807060504030201, n: 8, sels: 32'h76543210};
        vecs[1] = '{keep: 8'h05, last: 1'b1, data: 64'h1122334455667788, n: 2, sels: 32'h00000020};
        vecs[2] = '{keep: 8'h80, last: 1'b0, data: 64'hA5A5A5A5A5A5A5A5, n: 1, sels: 32'h00000007};
        vecs[3] = '{keep: 8'h5A, last: 1'b1, data: 64'hDEADBEEFCAFEF00D, n: 4, sels: 32'h00006431};
        vecs[4] = '{keep: 8'h01, last: 1'b1, data: 64'h0123456789ABCDEF, n: 1, sels: 32'h00000000};
        vecs[5] = '{keep: 8'h81, last: 1'b0, data: 64'hFEDCBA9876543210, n: 2, sels: 32'h00000070};
        vecs[6] = '{keep: 8'h0C, last: 1'b1, data: 64'h55AA55AA55AA55AA, n: 2, sels: 32'h00000032};

        reset         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_keep   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        chk("rst ready", 64'(bus.in_ready), 64'd0);
        chk("rst valid", 64'(bus.byte_valid), 64'd0);
        chk("rst last", 64'(bus.byte_last), 64'd0);
        chk("rst sel", 64'(bus.mux_sel), 64'd0);
        chk("rst en", 64'(bus.mux_en), 64'd0);
        chk("rst word", bus.word_q, 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("post-rst ready", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        chk("idle en", 64'(bus.mux_en), 64'd0);
        chk("idle valid", 64'(bus.byte_valid), 64'd0);

        for (int unsigned k = 0; k < 6; k++) run_vec(k);

        // Downstream stall while lane 3 is presented.
        bus.in_valid  = 1'b1;
        bus.in_data   = 64'h8877665544332211;
        bus.in_keep   = 8'hFF;
        bus.in_last   = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int unsigned j = 0; j < 3; j++) begin
            chk($sformatf("stall pre sel%0d", j), 64'(bus.mux_sel), 64'(j));
            @(negedge clk);
        end
        chk("stall at3 sel", 64'(bus.mux_sel), 64'd3);
        bus.out_ready = 1'b0;
        for (int unsigned j = 0; j < 3; j++) begin
            @(negedge clk);
            chk($sformatf("stall%0d sel", j), 64'(bus.mux_sel), 64'd3);
            chk($sformatf("stall%0d valid", j), 64'(bus.byte_valid), 64'd1);
            chk($sformatf("stall%0d word", j), bus.word_q, 64'h8877665544332211);
            chk($sformatf("stall%0d ready", j), 64'(bus.in_ready), 64'd0);
        end
        bus.out_ready = 1'b1;
        for (int unsigned j = 4; j < 8; j++) begin
            @(negedge clk);
            chk($sformatf("stall post sel%0d", j), 64'(bus.mux_sel), 64'(j));
            chk($sformatf("stall post last%0d", j), 64'(bus.byte_last), 64'(j == 7));
        end
        @(negedge clk);
        chk("stall end valid", 64'(bus.byte_valid), 64'd0);

        // Two full words back to back with in_valid held.
        bus.in_valid = 1'b1;
        bus.in_data  = 64'h1111111111111111;
        bus.in_keep  = 8'hFF;
        bus.in_last  = 1'b0;
        @(negedge clk);
        bus.in_data = 64'h2222222222222222;
        bus.in_last = 1'b1;
        for (int unsigned j = 0; j < 16; j++) begin
            chk($sformatf("b2b%0d valid", j), 64'(bus.byte_valid), 64'd1);
            chk($sformatf("b2b%0d sel", j), 64'(bus.mux_sel), 64'(j % 8));
            chk($sformatf("b2b%0d ready", j), 64'(bus.in_ready), 64'((j % 8) == 7));
            chk($sformatf("b2b%0d last", j), 64'(bus.byte_last), 64'(j == 15));
            chk($sformatf("b2b%0d word", j), bus.word_q,
                (j < 8) ? 64'h1111111111111111 : 64'h2222222222222222);
            if (j == 8) bus.in_valid = 1'b0;
            @(negedge clk);
        end
        chk("b2b end valid", 64'(bus.byte_valid), 64'd0);

        // Empty keep: accepted and dropped, then a normal word.
        bus.in_valid = 1'b1;
        bus.in_data  = 64'hFFFFFFFFFFFFFFFF;
        bus.in_keep  = 8'h00;
        bus.in_last  = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("keep0 valid", 64'(bus.byte_valid), 64'd0);
        chk("keep0 ready", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        chk("keep0 valid2", 64'(bus.byte_valid), 64'd0);
        run_vec(1);

        // Reset in the middle of a word.
        bus.in_valid = 1'b1;
        bus.in_data  = 64'h0F0E0D0C0B0A0908;
        bus.in_keep  = 8'hFF;
        bus.in_last  = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int unsigned j = 0; j < 4; j++) @(negedge clk);
        chk("midrst pre sel", 64'(bus.mux_sel), 64'd4);
        reset = 1'b0;
        #1;
        chk("midrst ready", 64'(bus.in_ready), 64'd0);
        chk("midrst valid", 64'(bus.byte_valid), 64'd0);
        chk("midrst last", 64'(bus.byte_last), 64'd0);
        chk("midrst sel", 64'(bus.mux_sel), 64'd0);
        chk("midrst en", 64'(bus.mux_en), 64'd0);
        chk("midrst word", bus.word_q, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midrst release ready", 64'(bus.in_ready), 64'd1);
        run_vec(6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

endmodule
